fifo_pkt_reader: RTL



---
 rtl/fifo_pkt_reader_if.sv | 46 ++++
 rtl/fifo_pkt_reader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader_if.sv
// Read-side FIFO port plus payload stream for fifo_pkt_reader.
// master: the reader (drives fifo_rden, out_*); slave: FIFO + sink.
interface fifo_pkt_reader_if #(
  parameter int WIDTH = 64,
  parameter int PTR   = 4
);
  localparam int MODW = $clog2(WIDTH / 8);

  logic             fifo_rden;
  logic [WIDTH-1:0] fifo_dataout;
  logic             fifo_rdempty;
  logic [PTR:0]     fifo_rdusedw;

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sop;
  logic             out_eop;
  logic [MODW-1:0]  out_mod;

  modport master (
    output fifo_rden,
    input  fifo_dataout,
    input  fifo_rdempty,
    input  fifo_rdusedw,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_sop,
    output out_eop,
    output out_mod
  );

  modport slave (
    input  fifo_rden,
    output fifo_dataout,
    output fifo_rdempty,
    output fifo_rdusedw,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_sop,
    input  out_eop,
    input  out_mod
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains a MAC rx FIFO: strips the length header, streams payload.
// Ports: clk, reset_ (sync, low), bus (FIFO + stream), pkt_len, err_len, busy.
module fifo_pkt_reader #(
  parameter int WIDTH   = 64,
  parameter int MAX_LEN = 1518,
  parameter int MODW    = $clog2(WIDTH / 8)
) (
  input  logic              clk,
  input  logic              reset_,
  fifo_pkt_reader_if.master bus,
  output logic [15:0]       pkt_len,
  output logic              err_len,
  output logic              busy
);
  localparam int BYTES = WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    TAIL
  } state_t;

  state_t state;

  logic [16:0]      rem;
  logic [16:0]      nwords;
  logic [MODW-1:0]  mod_q;
  logic [1:0]       occ;
  logic [1:0]       occ_nx;
  logic             inflight;
  logic             tag_sop;
  logic             tag_eop;

  // second skid entry; the head entry is the out_* registers
  logic [WIDTH-1:0] d1;
  logic             s1;
  logic             e1;
  logic [MODW-1:0]  m1;

  logic [15:0]      hdr_len;
  logic [16:0]      hdr_nw;
  logic             hdr_bad;
  logic             pop;
  logic             rd_ok;
  logic [2:0]       credit;

  assign hdr_len = bus.fifo_dataout[15:0];
  assign hdr_nw  = ({1'b0, hdr_len} + 17'(BYTES - 1)) >> LOG2B;
  assign hdr_bad = (hdr_len == 16'd0)
                || ({16'd0, hdr_len} > 32'(MAX_LEN));

  assign pop    = bus.out_valid & bus.out_ready;
  // words already owed to the buffer after this cycle's pop
  assign credit = {1'b0, occ}
                + {2'b00, inflight}
                - {2'b00, pop};
  assign occ_nx = 2'(credit);

  always_comb begin
    rd_ok = 1'b0;
    unique case (state)
      IDLE:    rd_ok = 1'b1;
      PAYLOAD: rd_ok = (rem != 17'd0)
                    && (credit < 3'd2);
      default: rd_ok = 1'b0;
    endcase
  end

  // gated by reset_ so no read is issued while held in reset
  assign bus.fifo_rden = reset_
                       & rd_ok
                       & ~bus.fifo_rdempty;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state         <= IDLE;
      busy          <= 1'b0;
      err_len       <= 1'b0;
      pkt_len       <= 16'd0;
      rem           <= 17'd0;
      nwords        <= 17'd0;
      mod_q         <= '0;
      occ           <= 2'd0;
      inflight      <= 1'b0;
      tag_sop       <= 1'b0;
      tag_eop       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_mod   <= '0;
      d1            <= '0;
      s1            <= 1'b0;
      e1            <= 1'b0;
      m1            <= '0;
    end else begin
      err_len  <= 1'b0;
      inflight <= bus.fifo_rden
                & (state == PAYLOAD);

      unique case (state)
        IDLE: begin
          if (bus.fifo_rden) begin
            state <= HDR;
            busy  <= 1'b1;
          end
        end
        HDR: begin
          if (hdr_bad) begin
            err_len <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            pkt_len <= hdr_len;
            nwords  <= hdr_nw;
            rem     <= hdr_nw;
            mod_q   <= hdr_len[MODW-1:0];
            state   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (bus.fifo_rden) begin
            tag_sop <= (rem == nwords);
            tag_eop <= (rem == 17'd1);
            rem     <= rem - 17'd1;
            if (rem == 17'd1) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (occ == 2'd0 && !inflight) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase

      // skid buffer: head lives in out_*, second entry in d1/s1/e1/m1
      unique case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            bus.out_data <= bus.fifo_dataout;
            bus.out_sop  <= tag_sop;
            bus.out_eop  <= tag_eop;
            bus.out_mod  <= mod_q;
          end else begin
            d1 <= bus.fifo_dataout;
            s1 <= tag_sop;
            e1 <= tag_eop;
            m1 <= mod_q;
          end
        end
        2'b01: begin
          bus.out_data <= d1;
          bus.out_sop  <= s1;
          bus.out_eop  <= e1;
          bus.out_mod  <= m1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            bus.out_data <= bus.fifo_dataout;
            bus.out_sop  <= tag_sop;
            bus.out_eop  <= tag_eop;
            bus.out_mod  <= mod_q;
          end else begin
            bus.out_data <= d1;
            bus.out_sop  <= s1;
            bus.out_eop  <= e1;
            bus.out_mod  <= m1;
            d1           <= bus.fifo_dataout;
            s1           <= tag_sop;
            e1           <= tag_eop;
            m1           <= mod_q;
          end
        end
        default: begin
        end
      endcase

      occ           <= occ_nx;
      bus.out_valid <= (occ_nx != 2'd0);
    end
  end
endmodule
